md_ctrl: RTL and testbench

// Multi-cycle multiply/divide sequencer owning the HI/LO register pair, sitting beside the E stage.
// - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, models fixed operation latency with a countdown.
// - Commits HI/LO at completion; a stall request holds any HI/LO-touching instruction in D.
// - Hazard/forwarding logic treats HI/LO as private to this block; mfhi/mflo read hi/lo directly.

---
 rtl/md_ctrl.sv | 162 ++++++++++++++++
 tb/tb_md_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer that owns the HI/LO pair and models fixed MULT/DIV latency.
// The result is computed in the start cycle and committed to HI/LO when the countdown expires.
module md_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // Datapath: products and quotients formed combinationally from the E-stage operands
    logic signed [63:0] rs_sx, rt_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] rt_safe;
    logic signed [31:0] rs_s, rt_s;
    logic        [31:0] quo_s, rem_s, quo_u, rem_u;
    logic               div_ovf;

    always_comb begin
        rs_sx   = {{32{rs_val[31]}}, rs_val};
        rt_sx   = {{32{rt_val[31]}}, rt_val};
        prod_s  = rs_sx * rt_sx;
        prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
        // A zero divisor is replaced by 1 so the divider never sees it; the result is discarded anyway
        rt_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
        rs_s    = $signed(rs_val);
        rt_s    = $signed(rt_safe);
        div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end else begin
            quo_s = 32'(rs_s / rt_s);
            rem_s = 32'(rs_s % rt_s);
        end
        quo_u = rs_val / rt_safe;
        rem_u = rs_val % rt_safe;
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state: accept ops in IDLE, count down in BUSY, commit at zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_LAT - 1);
                            state_d   = BUSY;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_LAT - 1);
                            state_d   = BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                            pend_wr_d = (rt_val != 32'd0);
                            cnt_d     = CNT_W'(DIV_LAT - 1);
                            state_d   = BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                            pend_wr_d = (rt_val != 32'd0);
                            cnt_d     = CNT_W'(DIV_LAT - 1);
                            state_d   = BUSY;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == BUSY);
    // Asserted in the start cycle too, so a trailing mfhi/mflo in D never reads stale HI/LO
    assign stall_md = d_uses_md & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: latency, arithmetic corners, MTHI/MTLO and stall.
module tb_md_ctrl;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .stall_md  (stall_md),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count busy cycles, check hold during busy and final HI/LO
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 0) begin
                check({tag, "_hold_hi"}, hi, m_hi);
                check({tag, "_hold_lo"}, lo, m_lo);
            end
            n++;
            tick();
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        start     = 1'b0;
        md_op     = 3'd0;
        rs_val    = '0;
        rt_val    = '0;
        d_uses_md = 1'b0;
        m_hi      = '0;
        m_lo      = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset_n = 1'b1;

        // Reset mid-MULT aborts it and clears a previously written HI
        start = 1'b1; md_op = 3'd4; rs_val = 32'hAAAA;
        tick();
        start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd5;
        tick();
        start = 1'b0;
        check("pre_rst_hi", hi, 32'hAAAA);
        check("pre_rst_busy", 32'(busy), 32'd1);
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_lo", lo, 32'd0);

        run_op("mult",  3'd0, 32'd3, 32'hFFFF_FFFE, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, MULT_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'd3, 32'd77, 32'd0, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd3, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000);
        run_op("div0",  3'd2, 32'd5, 32'd0, DIV_LAT, 32'd0, 32'h8000_0000);

        // Reserved op has no effect
        run_op("rsvd", 3'd6, 32'h1111, 32'h2222, 0, 32'd0, 32'h8000_0000);

        // MTHI then MTLO back-to-back
        start = 1'b1; md_op = 3'd4; rs_val = 32'h1234;
        tick();
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'h1234);
        md_op = 3'd5; rs_val = 32'h5678;
        tick();
        start = 1'b0;
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_hi", hi, 32'h1234);
        check("mtlo_lo", lo, 32'h5678);

        // Stall window: start cycle plus every busy cycle; extra start while busy ignored
        d_uses_md = 1'b1;
        start = 1'b0;
        #1;
        check("stall_idle", 32'(stall_md), 32'd0);
        start = 1'b1; md_op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
        #1;
        check("stall_start", 32'(stall_md), 32'd1);
        tick();
        start = 1'b1; md_op = 3'd4; rs_val = 32'hDEAD;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            check("stall_busy", 32'(stall_md), 32'd1);
            n++;
            tick();
            start = 1'b0;
        end
        check("stall_lat", 32'(n), 32'(MULT_LAT));
        check("stall_after", 32'(stall_md), 32'd0);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd6);
        d_uses_md = 1'b0;
        start = 1'b1; md_op = 3'd1; rs_val = 32'd1; rt_val = 32'd1;
        #1;
        check("nostall_start", 32'(stall_md), 32'd0);
        tick();
        start = 1'b0;
        check("nostall_busy", 32'(stall_md), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
